// File: rtl/hilo_unit.sv
// hilo_unit: architectural HI/LO register pair fed by the multiplier result
// handshake. Tracks one outstanding mul-class op (write, accumulate-add,
// accumulate-subtract), services MTHI/MTLO, and drains results of flushed ops.
module hilo_unit #(
    parameter int unsigned DRAIN_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    input  logic [1:0]  op_kind,
    output logic        op_ready,
    input  logic        res_valid,
    input  logic [63:0] res_data,
    output logic        res_ready,
    input  logic        flush,
    input  logic        mthi_we,
    input  logic        mtlo_we,
    input  logic [31:0] mt_data,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        hilo_busy,
    output logic        commit
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_ACC   = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    localparam logic [1:0] K_ADD = 2'd1;
    localparam logic [1:0] K_SUB = 2'd2;

    localparam int unsigned CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DRAIN_CYCLES - 1);

    logic [1:0]    r_state;
    logic [1:0]    r_kind;
    logic [63:0]   r_acc;
    logic [CW-1:0] r_cnt;
    logic [31:0]   r_hi;
    logic [31:0]   r_lo;
    logic          r_commit;

    logic          w_hs;
    logic          w_accept;
    logic          w_kind_acc;
    logic [63:0]   w_hilo;
    logic [63:0]   w_acc_result;

    assign res_ready  = (r_state != S_ACC);
    assign op_ready   = (r_state == S_IDLE);
    assign hilo_busy  = (r_state != S_IDLE);
    assign hi         = r_hi;
    assign lo         = r_lo;
    assign commit     = r_commit;

    assign w_hs       = res_valid & res_ready;
    assign w_accept   = op_valid & op_ready & ~flush;
    assign w_kind_acc = (r_kind == K_ADD) || (r_kind == K_SUB);
    assign w_hilo     = {r_hi, r_lo};

    // Accumulate result, modulo 2^64; only the add/sub kinds ever reach ACC
    always_comb begin
        w_acc_result = w_hilo + r_acc;
        if (r_kind == K_SUB) begin
            w_acc_result = w_hilo - r_acc;
        end
    end

    // Op tracking FSM, HI/LO update and one-cycle commit pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_kind   <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_commit <= 1'b0;
        end else begin
            r_commit <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // A result arriving here is stale and simply dropped.
                    if (mthi_we) r_hi <= mt_data;
                    if (mtlo_we) r_lo <= mt_data;
                    if (w_accept) begin
                        r_kind  <= op_kind;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (flush) begin
                        if (w_hs) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_cnt   <= '0;
                            r_state <= S_DRAIN;
                        end
                    end else if (w_hs) begin
                        if (w_kind_acc) begin
                            r_acc   <= res_data;
                            r_state <= S_ACC;
                        end else begin
                            {r_hi, r_lo} <= res_data;
                            r_commit     <= 1'b1;
                            r_state      <= S_IDLE;
                        end
                    end
                end
                S_ACC: begin
                    if (!flush) begin
                        {r_hi, r_lo} <= w_acc_result;
                        r_commit     <= 1'b1;
                    end
                    r_state <= S_IDLE;
                end
                default: begin
                    // DRAIN: leave on the flushed result or once the window expires.
                    if (w_hs || (r_cnt == CNT_LAST)) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_unit.sv
// Self-checking bench for hilo_unit: scenario tasks with randomized data,
// expected HI/LO computed by plain 64-bit arithmetic on a model value.
module tb_hilo_unit;

    localparam int unsigned DC = 4;

    logic        clk;
    logic        rst;
    logic        op_valid;
    logic [1:0]  op_kind;
    logic        op_ready;
    logic        res_valid;
    logic [63:0] res_data;
    logic        res_ready;
    logic        flush;
    logic        mthi_we;
    logic        mtlo_we;
    logic [31:0] mt_data;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        hilo_busy;
    logic        commit;

    int errors = 0;
    int checks = 0;
    logic [63:0] m_hilo;

    hilo_unit #(.DRAIN_CYCLES(DC)) dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op_kind(op_kind),
        .op_ready(op_ready), .res_valid(res_valid), .res_data(res_data),
        .res_ready(res_ready), .flush(flush), .mthi_we(mthi_we),
        .mtlo_we(mtlo_we), .mt_data(mt_data), .hi(hi), .lo(lo),
        .hilo_busy(hilo_busy), .commit(commit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        op_valid = 0; op_kind = 0; res_valid = 0; res_data = '0;
        flush = 0; mthi_we = 0; mtlo_we = 0; mt_data = '0;
    endtask

    task automatic set_hilo(input logic [63:0] v);
        mthi_we = 1; mt_data = v[63:32]; tick();
        mthi_we = 0; mtlo_we = 1; mt_data = v[31:0]; tick();
        mtlo_we = 0;
        m_hilo = v;
    endtask

    task automatic issue_op(input logic [1:0] k);
        op_valid = 1; op_kind = k; tick();
        op_valid = 0;
    endtask

    task automatic test_reset();
        rst = 0; quiet();
        tick(); tick();
        checks++; if ({hi, lo} !== 64'h0) begin errors++; $display("FAIL reset_hilo: got %h want 0", {hi, lo}); end
        checks++; if ({commit, hilo_busy} !== 2'b00) begin errors++; $display("FAIL reset_flags: commit/busy got %b want 00", {commit, hilo_busy}); end
        checks++; if ({res_ready, op_ready} !== 2'b11) begin errors++; $display("FAIL reset_ready: got %b want 11", {res_ready, op_ready}); end
        rst = 1; tick();
        m_hilo = '0;
    endtask

    task automatic test_write();
        for (int n = 0; n < 6; n++) begin
            logic [63:0] r;
            int unsigned d;
            r = (n == 0) ? 64'h0000_0001_FFFF_FFFE : {$urandom, $urandom};
            d = (n == 0) ? 2 : $urandom_range(0, 3);
            issue_op(2'(n == 5 ? 3 : 0));
            checks++; if ({hilo_busy, op_ready} !== 2'b10) begin errors++; $display("FAIL wr_busy: busy/op_ready got %b want 10", {hilo_busy, op_ready}); end
            repeat (d) tick();
            res_valid = 1; res_data = r;
            checks++; if (res_ready !== 1'b1) begin errors++; $display("FAIL wr_res_ready: got %b want 1", res_ready); end
            tick(); res_valid = 0;
            checks++; if ({hi, lo} !== r) begin errors++; $display("FAIL wr_hilo: got %h want %h", {hi, lo}, r); end
            checks++; if ({commit, hilo_busy, op_ready} !== 3'b101) begin errors++; $display("FAIL wr_commit: commit/busy/op_ready got %b want 101", {commit, hilo_busy, op_ready}); end
            tick();
            checks++; if (commit !== 1'b0) begin errors++; $display("FAIL wr_commit_once: got %b want 0", commit); end
            m_hilo = r;
        end
    endtask

    task automatic test_accumulate();
        for (int n = 0; n < 8; n++) begin
            logic [63:0] base, r, exp;
            logic [1:0] k;
            if (n == 0) begin base = 64'h0000_0000_FFFF_FFFF; r = 64'h1; k = 1; end
            else if (n == 1) begin base = 64'h0; r = 64'h1; k = 2; end
            else begin base = {$urandom, $urandom}; r = {$urandom, $urandom}; k = 2'($urandom_range(1, 2)); end
            exp = (k == 1) ? base + r : base - r;
            set_hilo(base);
            issue_op(k);
            res_valid = 1; res_data = r; tick(); res_valid = 0;
            checks++; if ({commit, hilo_busy, res_ready} !== 3'b010) begin errors++; $display("FAIL acc_phase: commit/busy/res_ready got %b want 010", {commit, hilo_busy, res_ready}); end
            checks++; if ({hi, lo} !== base) begin errors++; $display("FAIL acc_early: got %h want %h", {hi, lo}, base); end
            tick();
            checks++; if ({hi, lo} !== exp) begin errors++; $display("FAIL acc_hilo k=%0d: got %h want %h", k, {hi, lo}, exp); end
            checks++; if ({commit, hilo_busy} !== 2'b10) begin errors++; $display("FAIL acc_commit: commit/busy got %b want 10", {commit, hilo_busy}); end
            tick();
            checks++; if (commit !== 1'b0) begin errors++; $display("FAIL acc_commit_once: got %b want 0", commit); end
            m_hilo = exp;
        end
    endtask

    task automatic test_flush_drain_result();
        logic [63:0] r;
        set_hilo({$urandom, $urandom});
        issue_op(0);
        flush = 1; tick(); flush = 0;
        tick();
        res_valid = 1; res_data = 64'hDEAD;
        checks++; if (res_ready !== 1'b1) begin errors++; $display("FAIL drain_res_ready: got %b want 1", res_ready); end
        tick(); res_valid = 0;
        checks++; if ({hi, lo} !== m_hilo) begin errors++; $display("FAIL drain_hilo: got %h want %h", {hi, lo}, m_hilo); end
        checks++; if ({commit, hilo_busy, op_ready} !== 3'b001) begin errors++; $display("FAIL drain_state: commit/busy/op_ready got %b want 001", {commit, hilo_busy, op_ready}); end
        r = {$urandom, $urandom};
        issue_op(0);
        res_valid = 1; res_data = r; tick(); res_valid = 0;
        checks++; if ({hi, lo, commit} !== {r, 1'b1}) begin errors++; $display("FAIL drain_next_op: got %h/%b want %h/1", {hi, lo}, commit, r); end
        m_hilo = r;
        tick();
    endtask

    task automatic test_flush_no_result();
        int n;
        issue_op(0);
        flush = 1; tick(); flush = 0;
        n = 0;
        while (hilo_busy && n < 20) begin
            tick();
            n++;
        end
        checks++; if (n != DC) begin errors++; $display("FAIL drain_timeout: busy cycles got %0d want %0d", n, DC); end
        checks++; if ({op_ready, commit} !== 2'b10) begin errors++; $display("FAIL drain_timeout_ready: op_ready/commit got %b want 10", {op_ready, commit}); end
        checks++; if ({hi, lo} !== m_hilo) begin errors++; $display("FAIL drain_timeout_hilo: got %h want %h", {hi, lo}, m_hilo); end
    endtask

    task automatic test_flush_cases();
        // flush together with the handshake in WAIT: result dropped
        issue_op(0);
        res_valid = 1; res_data = {$urandom, $urandom}; flush = 1; tick();
        res_valid = 0; flush = 0;
        checks++; if ({hi, lo} !== m_hilo) begin errors++; $display("FAIL flush_hs_hilo: got %h want %h", {hi, lo}, m_hilo); end
        checks++; if ({commit, hilo_busy} !== 2'b00) begin errors++; $display("FAIL flush_hs_state: commit/busy got %b want 00", {commit, hilo_busy}); end
        // flush in ACC aborts the accumulate
        issue_op(1);
        res_valid = 1; res_data = {$urandom, $urandom}; tick(); res_valid = 0;
        flush = 1; tick(); flush = 0;
        checks++; if ({hi, lo} !== m_hilo) begin errors++; $display("FAIL flush_acc_hilo: got %h want %h", {hi, lo}, m_hilo); end
        checks++; if ({commit, hilo_busy} !== 2'b00) begin errors++; $display("FAIL flush_acc_state: commit/busy got %b want 00", {commit, hilo_busy}); end
        // stale result in IDLE is accepted and dropped
        res_valid = 1; res_data = {$urandom, $urandom};
        checks++; if (res_ready !== 1'b1) begin errors++; $display("FAIL stale_ready: got %b want 1", res_ready); end
        tick(); res_valid = 0;
        checks++; if ({hi, lo, commit, hilo_busy} !== {m_hilo, 2'b00}) begin errors++; $display("FAIL stale_hilo: got %h/%b%b want %h/00", {hi, lo}, commit, hilo_busy, m_hilo); end
        // flush in IDLE blocks acceptance but MTLO still lands
        op_valid = 1; flush = 1; mtlo_we = 1; mt_data = $urandom; tick();
        m_hilo[31:0] = mt_data;
        quiet();
        checks++; if ({hilo_busy, lo} !== {1'b0, m_hilo[31:0]}) begin errors++; $display("FAIL idle_flush: busy/lo got %b/%h want 0/%h", hilo_busy, lo, m_hilo[31:0]); end
    endtask

    task automatic test_mt();
        logic [63:0] r1, r2;
        r1 = {$urandom, $urandom};
        r2 = {$urandom, $urandom};
        issue_op(0);
        mthi_we = 1; mt_data = 32'h1234; tick(); mthi_we = 0;
        checks++; if ({hi, lo} !== m_hilo) begin errors++; $display("FAIL mt_wait_ignored: got %h want %h", {hi, lo}, m_hilo); end
        res_valid = 1; res_data = r1; tick(); res_valid = 0;
        m_hilo = r1;
        mthi_we = 1; mt_data = 32'h1234; op_valid = 1; op_kind = 0; tick();
        mthi_we = 0; op_valid = 0;
        m_hilo[63:32] = 32'h1234;
        checks++; if ({hi, lo} !== m_hilo) begin errors++; $display("FAIL mt_idle_hilo: got %h want %h", {hi, lo}, m_hilo); end
        checks++; if (hilo_busy !== 1'b1) begin errors++; $display("FAIL mt_idle_accept: busy got %b want 1", hilo_busy); end
        res_valid = 1; res_data = r2; tick(); res_valid = 0;
        checks++; if ({hi, lo, commit} !== {r2, 1'b1}) begin errors++; $display("FAIL mt_op_commit: got %h/%b want %h/1", {hi, lo}, commit, r2); end
        m_hilo = r2;
        tick();
    endtask

    task automatic test_reset_during_acc();
        set_hilo({$urandom | 32'h1, $urandom});
        issue_op(1);
        res_valid = 1; res_data = {$urandom, $urandom}; tick(); res_valid = 0;
        #2 rst = 0;
        #1;
        checks++; if ({hi, lo} !== 64'h0) begin errors++; $display("FAIL rst_acc_hilo: got %h want 0", {hi, lo}); end
        checks++; if ({commit, hilo_busy, op_ready} !== 3'b001) begin errors++; $display("FAIL rst_acc_state: commit/busy/op_ready got %b want 001", {commit, hilo_busy, op_ready}); end
        tick(); rst = 1;
        m_hilo = '0;
        res_valid = 1; res_data = {$urandom, $urandom}; tick(); res_valid = 0;
        checks++; if ({hi, lo, commit} !== 65'h0) begin errors++; $display("FAIL rst_late_result: got %h/%b want 0/0", {hi, lo}, commit); end
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 10; n++) begin
            logic [63:0] r;
            logic [1:0] k;
            r = {$urandom, $urandom};
            k = 2'($urandom_range(0, 3));
            issue_op(k);
            res_valid = 1; res_data = r; tick(); res_valid = 0;
            if (k == 1) m_hilo = m_hilo + r;
            else if (k == 2) m_hilo = m_hilo - r;
            else m_hilo = r;
            if (k == 1 || k == 2) tick();
            checks++; if ({hi, lo, commit} !== {m_hilo, 1'b1}) begin errors++; $display("FAIL b2b k=%0d: got %h/%b want %h/1", k, {hi, lo}, commit, m_hilo); end
        end
    endtask

    initial begin
        quiet();
        rst = 0;
        test_reset();
        test_write();
        test_accumulate();
        test_flush_drain_result();
        test_flush_no_result();
        test_flush_cases();
        test_mt();
        test_reset_during_acc();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
